// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                fetch FSM state encoding, default address/instruction widths
//                and the value held in the instruction register after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int ADDR_W_DEFAULT  = 32;
    localparam int INSTR_W_DEFAULT = 32;

    // Value held in the instruction register before any fetch completes.
    localparam logic [INSTR_W_DEFAULT-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // waiting for enable, nothing outstanding
        REQ  = 2'd1,    // request presented, waiting for handshake
        WAIT = 2'd2,    // request accepted, waiting for response
        HOLD = 2'd3     // instruction presented to decode
    } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Non-pipelined instruction fetch. Samples the PC, issues one
//                instruction-memory read at a time (valid/ready request,
//                valid-only response), holds the word for decode and pulses
//                pc_advance when decode accepts it. A branch redirect squashes
//                the in-flight or held instruction and refetches from pc_in.
//  Ports       : clk, reset (sync, active-high)
//                enable, pc_in, redirect, pc_advance   - PC unit side
//                imem_req_valid/ready/addr             - memory request
//                imem_rsp_valid/data                   - memory response
//                instr_valid/ready, instr, instr_pc    - decode side
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    // PC unit
    input  logic               enable,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               redirect,
    output logic               pc_advance,
    // instruction memory request
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    // instruction memory response
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    // decode
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [ADDR_W-1:0]  w_req_addr_nxt;
    // Set when a redirect arrives after the current request was committed to;
    // the matching response is then stale and must be dropped.
    logic               r_discard;
    logic               w_discard_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic [ADDR_W-1:0]  w_instr_pc_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req_addr <= '0;
            r_discard  <= 1'b0;
            r_instr    <= INSTR_W'(NOP_INSTR);
            r_instr_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_discard  <= w_discard_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_req_addr_nxt = r_req_addr;
        w_discard_nxt  = r_discard;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        pc_advance     = 1'b0;

        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_req_addr_nxt = pc_in;
                    w_state_nxt    = REQ;
                end
            end

            REQ: begin
                imem_req_valid = 1'b1;
                // The request address must not move mid-handshake, so a
                // redirect here lets the request finish and marks its
                // response for disposal instead.
                if (redirect) begin
                    w_discard_nxt = 1'b1;
                end
                if (imem_req_ready) begin
                    w_state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_discard || redirect) begin
                        // Stale response: refetch from the redirect target,
                        // which the PC unit is already presenting on pc_in.
                        w_discard_nxt  = 1'b0;
                        w_req_addr_nxt = pc_in;
                        w_state_nxt    = REQ;
                    end else begin
                        w_instr_nxt    = imem_rsp_data;
                        w_instr_pc_nxt = r_req_addr;
                        w_state_nxt    = HOLD;
                    end
                end else if (redirect) begin
                    w_discard_nxt = 1'b1;
                end
            end

            HOLD: begin
                instr_valid = 1'b1;
                // Redirect takes priority: the held instruction is on the
                // wrong path, so decode must not be told it was consumed.
                if (redirect) begin
                    w_req_addr_nxt = pc_in;
                    w_state_nxt    = REQ;
                end else if (instr_ready) begin
                    pc_advance  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req_addr = r_req_addr;
    assign instr         = r_instr;
    assign instr_pc      = r_instr_pc;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. A ROM-backed memory
//                model with configurable latency/backpressure and a PC-unit
//                model drive the DUT. The reference is architectural: every
//                instruction decode accepts must be the ROM word at the current
//                program counter, where the counter steps by one per accepted
//                instruction and jumps to the target on each redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int AW = 32;
    localparam int IW = 32;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [AW-1:0] pc_in;
    logic          redirect;
    logic          pc_advance;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;

    instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .pc_in          (pc_in),
        .redirect       (redirect),
        .pc_advance     (pc_advance),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference state ----------------
    logic [IW-1:0] rom [256];
    logic [AW-1:0] model_pc;        // architectural PC held by the PC-unit model
    int            adv_count;
    int            n_cmp;
    int            n_err;

    // memory model controls / state
    int            lat_cfg;         // 0 = random 1..4 per request
    bit            ready_rand;
    bit            ready_ctl;
    bit            pending;
    int            lat_cnt;
    logic [AW-1:0] mem_addr;
    bit            prev_stall;
    logic [AW-1:0] prev_addr;

    // values seen at the most recent mid-cycle sample
    logic          s_pc_adv, s_req_valid, s_instr_valid, s_hs;
    logic [AW-1:0] s_req_addr, s_instr_pc;
    logic [IW-1:0] s_instr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: sample at negedge, update models, then drive memory/PC
    // inputs 1ns after the rising edge.
    task automatic cycle();
        @(negedge clk);
        s_pc_adv      = pc_advance;
        s_req_valid   = imem_req_valid;
        s_req_addr    = imem_req_addr;
        s_instr_valid = instr_valid;
        s_instr       = instr;
        s_instr_pc    = instr_pc;
        s_hs          = imem_req_valid & imem_req_ready;
        if (reset) begin
            pending    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (redirect) check("no_adv_on_redirect", 64'(pc_advance), 64'd0);
            if (pc_advance) begin
                check("adv_instr_valid", 64'(instr_valid), 64'd1);
                check("adv_instr_pc", 64'(instr_pc), 64'(model_pc));
                check("adv_instr", 64'(instr), 64'(rom[model_pc[7:0]]));
                model_pc  = model_pc + 1;
                adv_count++;
            end
            if (prev_stall) check("req_addr_stable", 64'(imem_req_addr), 64'(prev_addr));
            prev_stall = imem_req_valid & ~imem_req_ready;
            prev_addr  = imem_req_addr;
            if (s_hs) begin
                pending  = 1'b1;
                lat_cnt  = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
                mem_addr = imem_req_addr;
            end
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (pending) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = rom[mem_addr[7:0]];
                pending        = 1'b0;
            end
        end
        imem_req_ready = ready_rand ? ($urandom_range(0, 9) < 7) : ready_ctl;
        pc_in          = model_pc;
    endtask

    task automatic do_redirect(input logic [AW-1:0] tgt);
        model_pc = tgt;
        pc_in    = tgt;
        redirect = 1'b1;
        cycle();
        redirect = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_instr_valid && n < 50);
        check({tag, "_timeout"}, 64'(s_instr_valid), 64'd1);
    endtask

    task automatic wait_hs(input string tag);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_hs && n < 50);
        check({tag, "_timeout"}, 64'(s_hs), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pc_adv"}, 64'(s_pc_adv), 64'd0);
        check({tag, "_req_valid"}, 64'(s_req_valid), 64'd0);
        check({tag, "_req_addr"}, 64'(s_req_addr), 64'd0);
        check({tag, "_instr_valid"}, 64'(s_instr_valid), 64'd0);
        check({tag, "_instr"}, 64'(s_instr), 64'd0);
        check({tag, "_instr_pc"}, 64'(s_instr_pc), 64'd0);
    endtask

    initial begin
        int n;
        int adv_before;
        n_cmp = 0; n_err = 0; adv_count = 0;
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0] = 32'h2002000A;
        reset = 1'b1; enable = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        pc_in = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_req_ready = 1'b1;
        lat_cfg = 1; ready_rand = 1'b0; ready_ctl = 1'b1;
        pending = 1'b0; lat_cnt = 0; mem_addr = '0; prev_stall = 1'b0; prev_addr = '0;
        model_pc = '0;

        // reset state
        repeat (3) cycle();
        cycle();
        check_zero("reset");

        // first fetch: latency from enable to instr_valid
        reset = 1'b0; enable = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_instr_valid && n < 20);
        check("t1_edges_to_valid", 64'(n - 1), 64'd3);
        check("t1_instr", 64'(s_instr), 64'h2002000A);
        check("t1_instr_pc", 64'(s_instr_pc), 64'd0);
        instr_ready = 1'b1; enable = 1'b0;
        cycle();
        check("t1_adv_pulse", 64'(s_pc_adv), 64'd1);
        cycle();
        check("t1_adv_single", 64'(s_pc_adv), 64'd0);
        check("t1_adv_count", 64'(adv_count), 64'd1);

        // sequential run 0..7
        reset = 1'b1; cycle(); reset = 1'b0;
        model_pc = '0; pc_in = '0; adv_count = 0;
        instr_ready = 1'b1; enable = 1'b1;
        n = 0;
        while (adv_count < 8 && n < 200) begin
            cycle();
            n++;
        end
        enable = 1'b0;
        repeat (5) cycle();
        check("t2_adv_count", 64'(adv_count), 64'd8);
        check("t2_final_pc", 64'(model_pc), 64'd8);

        // memory backpressure, then decode stall
        instr_ready = 1'b0; ready_ctl = 1'b0; enable = 1'b1;
        cycle();
        repeat (4) begin
            cycle();
            check("t3_req_valid_held", 64'(s_req_valid), 64'd1);
            check("t3_req_addr_held", 64'(s_req_addr), 64'd8);
        end
        ready_ctl = 1'b1;
        wait_valid("t3_valid");
        repeat (5) begin
            cycle();
            check("t3_stall_valid", 64'(s_instr_valid), 64'd1);
            check("t3_stall_instr", 64'(s_instr), 64'(rom[8]));
            check("t3_stall_pc", 64'(s_instr_pc), 64'd8);
            check("t3_stall_no_adv", 64'(s_pc_adv), 64'd0);
        end
        instr_ready = 1'b1; enable = 1'b0;
        cycle();
        instr_ready = 1'b0;

        // redirect while waiting on a 3-cycle memory
        lat_cfg = 3; enable = 1'b1;
        wait_hs("t4_hs");
        do_redirect(32'h40);
        wait_valid("t4_valid");
        check("t4_instr_pc", 64'(s_instr_pc), 64'h40);
        check("t4_instr", 64'(s_instr), 64'(rom[8'h40]));
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        // redirect coincident with the response
        n = 0;
        while (!imem_rsp_valid && n < 50) begin
            cycle();
            n++;
        end
        check("t4b_rsp_seen", 64'(imem_rsp_valid), 64'd1);
        do_redirect(32'h60);
        wait_valid("t4b_valid");
        check("t4b_instr_pc", 64'(s_instr_pc), 64'h60);
        check("t4b_instr", 64'(s_instr), 64'(rom[8'h60]));

        // redirect together with instr_ready in HOLD
        instr_ready = 1'b1;
        do_redirect(32'h80);
        check("t5_no_adv", 64'(s_pc_adv), 64'd0);
        instr_ready = 1'b0;
        cycle();
        check("t5_valid_dropped", 64'(s_instr_valid), 64'd0);
        check("t5_req_valid", 64'(s_req_valid), 64'd1);
        check("t5_req_addr", 64'(s_req_addr), 64'h80);
        wait_valid("t5_valid");
        check("t5_instr_pc", 64'(s_instr_pc), 64'h80);
        instr_ready = 1'b1; enable = 1'b0;
        cycle();
        instr_ready = 1'b0;

        // reset in WAIT, reset in HOLD, enable=0 holds IDLE
        enable = 1'b1;
        wait_hs("t6_hs");
        reset = 1'b1;
        cycle();
        cycle();
        check_zero("t6_rst_wait");
        reset = 1'b0;
        wait_valid("t6_valid");
        reset = 1'b1;
        cycle();
        cycle();
        check_zero("t6_rst_hold");
        reset = 1'b0; enable = 1'b0;
        repeat (5) begin
            cycle();
            check("t6_idle_req", 64'(s_req_valid), 64'd0);
            check("t6_idle_valid", 64'(s_instr_valid), 64'd0);
        end

        // randomized traffic against the architectural model
        lat_cfg = 0; ready_rand = 1'b1;
        adv_before = adv_count;
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 9) < 6);
            enable      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 4) do_redirect($urandom);
            else cycle();
        end
        check("rand_progress", 64'(adv_count - adv_before > 100), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
